// File: rtl/spi_imu_responder.sv
// SPI mode-0 responder standing in for the JB IMU: returns a status byte during
// the command byte, then streams a snapshot of nine 16-bit sensor words MSB first.
module spi_imu_responder #(
    parameter logic [7:0] STATUS_BYTE  = 8'hA5,
    parameter logic [7:0] CMD_READ_ALL = 8'h01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ss,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    input  logic [15:0] roll,
    input  logic [15:0] pitch,
    input  logic [15:0] yaw,
    input  logic [15:0] roll_rate,
    input  logic [15:0] pitch_rate,
    input  logic [15:0] yaw_rate,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    output logic [7:0]  cmd,
    output logic        cmd_valid,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned N_WORDS = 9;
    localparam logic [4:0]  LAST_DATA_IDX = 5'd18;
    localparam logic [4:0]  SAT_IDX       = 5'd19;

    typedef enum logic [1:0] {IDLE, CMD, STREAM, FILL} state_e;

    state_e                          state_q, state_d;
    logic                            ss_meta_q, ss_sync_q, ss_dly_q;
    logic                            ss_meta_d, ss_sync_d, ss_dly_d;
    logic                            sck_meta_q, sck_sync_q, sck_dly_q;
    logic                            sck_meta_d, sck_sync_d, sck_dly_d;
    logic                            mosi_meta_q, mosi_sync_q;
    logic                            mosi_meta_d, mosi_sync_d;
    logic [BYTE_W-1:0]               rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]               tx_shift_q, tx_shift_d;
    logic [2:0]                      bit_cnt_q, bit_cnt_d;
    logic [4:0]                      byte_idx_q, byte_idx_d;
    logic                            rise_seen_q, rise_seen_d;
    logic [N_WORDS-1:0][WORD_W-1:0]  snap_q, snap_d;
    logic [BYTE_W-1:0]               cmd_q, cmd_d;
    logic                            cmd_valid_q, cmd_valid_d;
    logic                            frame_done_q, frame_done_d;
    logic                            busy_q, busy_d;
    logic                            miso_q, miso_d;

    logic                            ss_fall, ss_rise, sck_rise, sck_fall;
    logic [BYTE_W-1:0]               rx_byte;
    logic [WORD_W-1:0]               cur_word;
    logic [BYTE_W-1:0]               stream_byte;

    assign ss_fall  = ss_dly_q & ~ss_sync_q;
    assign ss_rise  = ~ss_dly_q & ss_sync_q;
    assign sck_rise = ~sck_dly_q & sck_sync_q;
    assign sck_fall = sck_dly_q & ~sck_sync_q;
    assign rx_byte  = {rx_shift_q[6:0], mosi_sync_q};

    // Data byte k (1..18) is selected by byte_idx = k-1; roll sits in the top word.
    always_comb begin
        case (byte_idx_q[4:1])
            4'd0:    cur_word = snap_q[8];
            4'd1:    cur_word = snap_q[7];
            4'd2:    cur_word = snap_q[6];
            4'd3:    cur_word = snap_q[5];
            4'd4:    cur_word = snap_q[4];
            4'd5:    cur_word = snap_q[3];
            4'd6:    cur_word = snap_q[2];
            4'd7:    cur_word = snap_q[1];
            default: cur_word = snap_q[0];
        endcase
        stream_byte = byte_idx_q[0] ? cur_word[7:0] : cur_word[15:8];
    end

    always_comb begin
        state_d      = state_q;
        ss_meta_d    = ss;
        ss_sync_d    = ss_meta_q;
        ss_dly_d     = ss_sync_q;
        sck_meta_d   = sck;
        sck_sync_d   = sck_meta_q;
        sck_dly_d    = sck_sync_q;
        mosi_meta_d  = mosi;
        mosi_sync_d  = mosi_meta_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        rise_seen_d  = rise_seen_q;
        snap_d       = snap_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        // Deselect overrides any coincident sck edge and drops the partial byte.
        if (ss_rise) begin
            state_d    = IDLE;
            tx_shift_d = '0;
            rx_shift_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        snap_d      = {roll, pitch, yaw, roll_rate, pitch_rate,
                                       yaw_rate, accel_x, accel_y, accel_z};
                        tx_shift_d  = STATUS_BYTE;
                        rx_shift_d  = '0;
                        bit_cnt_d   = '0;
                        byte_idx_d  = '0;
                        rise_seen_d = 1'b0;
                        state_d     = CMD;
                    end
                end
                default: begin
                    if (sck_rise) begin
                        rx_shift_d  = rx_byte;
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        rise_seen_d = 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == CMD) begin
                                cmd_d       = rx_byte;
                                cmd_valid_d = 1'b1;
                                state_d     = (rx_byte == CMD_READ_ALL) ? STREAM : FILL;
                            end else if (state_q == STREAM && byte_idx_q == LAST_DATA_IDX) begin
                                frame_done_d = 1'b1;
                                state_d      = FILL;
                            end
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt_q == 3'd0 && rise_seen_q) begin
                            tx_shift_d = (state_q == STREAM) ? stream_byte : '0;
                            byte_idx_d = (byte_idx_q == SAT_IDX) ? SAT_IDX : byte_idx_q + 5'd1;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
            endcase
        end

        busy_d = (state_d != IDLE);
        miso_d = (state_d != IDLE) & tx_shift_d[7];
    end

    // ss synchronisers clear to "selected" so a reset while ss is low cannot look like a new frame start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ss_meta_q    <= 1'b0;
            ss_sync_q    <= 1'b0;
            ss_dly_q     <= 1'b0;
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_dly_q    <= 1'b0;
            mosi_meta_q  <= 1'b0;
            mosi_sync_q  <= 1'b0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            rise_seen_q  <= 1'b0;
            snap_q       <= '0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ss_meta_q    <= ss_meta_d;
            ss_sync_q    <= ss_sync_d;
            ss_dly_q     <= ss_dly_d;
            sck_meta_q   <= sck_meta_d;
            sck_sync_q   <= sck_sync_d;
            sck_dly_q    <= sck_dly_d;
            mosi_meta_q  <= mosi_meta_d;
            mosi_sync_q  <= mosi_sync_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            rise_seen_q  <= rise_seen_d;
            snap_q       <= snap_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            miso_q       <= miso_d;
        end
    end

    assign miso       = miso_q;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_imu_responder.sv
// Bench for spi_imu_responder: a mode-0 SPI master with a scoreboard of the
// bytes the responder should return, plus pulse monitors for cmd_valid/frame_done.
module tb_spi_imu_responder;

    localparam int HALF = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        ss, sck, mosi;
    logic        miso;
    logic [15:0] w [9];
    logic [7:0]  cmd;
    logic        cmd_valid, frame_done, busy;

    int          checks   = 0;
    int          failures = 0;
    int          cv_cnt   = 0;
    int          fd_cnt   = 0;
    int          fd_at    = -1;
    int          xfer_idx = -1;
    logic [7:0]  cmd_last = 8'h00;
    logic [7:0]  exp_q [$];

    spi_imu_responder dut (
        .clock      (clock),
        .reset      (reset),
        .ss         (ss),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .roll       (w[0]),
        .pitch      (w[1]),
        .yaw        (w[2]),
        .roll_rate  (w[3]),
        .pitch_rate (w[4]),
        .yaw_rate   (w[5]),
        .accel_x    (w[6]),
        .accel_y    (w[7]),
        .accel_z    (w[8]),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (cmd_valid) begin
            cv_cnt   = cv_cnt + 1;
            cmd_last = cmd;
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_at  = xfer_idx;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            mosi = tx[b];
            repeat (HALF) @(negedge clock);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            repeat (HALF) @(negedge clock);
            sck = 1'b0;
        end
    endtask

    // One ss-low frame: command byte plus n_data bytes; optional mid-frame input change.
    task automatic run_frame(input string name, input logic [7:0] c, input int n_data, input bit mutate);
        logic [15:0] sw [9];
        logic [7:0]  rxb, e, tx;
        for (int i = 0; i < 9; i++) sw[i] = w[i];
        ss = 1'b0;
        repeat (8) @(negedge clock);
        chk({name, " busy"}, 32'(busy), 32'd1);
        for (int k = 0; k <= n_data; k++) begin
            xfer_idx = k;
            if (k == 0)
                e = 8'hA5;
            else if (c == 8'h01 && k <= 18)
                e = (k % 2 == 1) ? sw[(k-1)/2][15:8] : sw[(k-1)/2][7:0];
            else
                e = 8'h00;
            exp_q.push_back(e);
            tx = (k == 0) ? c : 8'(k * 37 + 5);
            spi_xfer(tx, rxb);
            e = exp_q.pop_front();
            chk($sformatf("%s byte%0d", name, k), 32'(rxb), 32'(e));
            if (mutate && k == 3)
                for (int i = 0; i < 9; i++) w[i] = ~w[i] + 16'(i);
        end
        repeat (HALF) @(negedge clock);
        ss = 1'b1;
        xfer_idx = -1;
        repeat (10) @(negedge clock);
        chk({name, " idle miso"}, 32'(miso), 32'd0);
        chk({name, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int cv0, fd0;
        w[0] = 16'h1234; w[1] = 16'h5678; w[2] = 16'h9ABC;
        w[3] = 16'hDEF0; w[4] = 16'h1357; w[5] = 16'h2468;
        w[6] = 16'hACE0; w[7] = 16'hBDF1; w[8] = 16'hFEDC;
        reset = 1'b1; ss = 1'b0; sck = 1'b0; mosi = 1'b0;

        // Reset held with ss low and sck toggling; responder must stay quiet afterwards too.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            sck = ~sck;
        end
        chk("rst miso", 32'(miso), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst cmd", 32'(cmd), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            repeat (4) @(negedge clock);
            sck = ~sck;
        end
        sck = 1'b0;
        chk("post-rst busy", 32'(busy), 32'd0);
        chk("post-rst miso", 32'(miso), 32'd0);
        chk("rst pulses", 32'(cv_cnt + fd_cnt), 32'd0);
        ss = 1'b1;
        repeat (10) @(negedge clock);

        cv0 = cv_cnt; fd0 = fd_cnt;
        run_frame("readall", 8'h01, 18, 1'b0);
        chk("readall cv", 32'(cv_cnt - cv0), 32'd1);
        chk("readall cmd", 32'(cmd_last), 32'h01);
        chk("readall fd", 32'(fd_cnt - fd0), 32'd1);
        chk("readall fd_at", 32'(fd_at), 32'd18);

        fd0 = fd_cnt;
        run_frame("snapshot", 8'h01, 18, 1'b1);
        chk("snapshot fd", 32'(fd_cnt - fd0), 32'd1);

        cv0 = cv_cnt; fd0 = fd_cnt;
        run_frame("badcmd", 8'h7F, 4, 1'b0);
        chk("badcmd cv", 32'(cv_cnt - cv0), 32'd1);
        chk("badcmd cmd", 32'(cmd_last), 32'h7F);
        chk("badcmd fd", 32'(fd_cnt - fd0), 32'd0);

        fd0 = fd_cnt; fd_at = -1;
        run_frame("overread", 8'h01, 20, 1'b0);
        chk("overread fd", 32'(fd_cnt - fd0), 32'd1);
        chk("overread fd_at", 32'(fd_at), 32'd18);

        fd0 = fd_cnt;
        run_frame("abort", 8'h01, 5, 1'b0);
        chk("abort fd", 32'(fd_cnt - fd0), 32'd0);
        fd0 = fd_cnt;
        run_frame("restart", 8'h01, 18, 1'b0);
        chk("restart fd", 32'(fd_cnt - fd0), 32'd1);
        chk("restart cmd", 32'(cmd_last), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
